// File: rtl/mips_pkg.sv
// Shared types and widths for the boot-time instruction loader.
// Imported by the loader, its byte assembler and the host interface.
package mips_pkg;

  localparam int INSTR_W     = 32;
  localparam int BYTE_W      = 8;
  localparam int WADDR_SHIFT = 2;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link (valid/ready) plus the instruction-memory write port.
// master = host/memory side, slave = loader side.
interface imem_loader_if;
  import mips_pkg::*;

  logic               rx_valid;
  logic [BYTE_W-1:0]  rx_byte;
  logic               rx_ready;
  logic               imem_we;
  logic [INSTR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output rx_valid,
    output rx_byte,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_byte,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/byte_word_assembler.sv
// Packs four MSB-first bytes into a word; word_valid_o pulses one cycle
// after the fourth byte, holding the finished word until the next one.
module byte_word_assembler
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               byte_valid_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic               word_done_o,
  output logic               word_valid_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [1:0]               idx_q, idx_d;
  logic [INSTR_W-BYTE_W-1:0] sh_q, sh_d;
  logic [INSTR_W-1:0]       word_q, word_d;
  logic                     vld_q, vld_d;

  assign word_done_o = byte_valid_i && (idx_q == 2'd3);

  always_comb begin
    idx_d  = idx_q;
    sh_d   = sh_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (clr_i) begin
      idx_d  = '0;
      sh_d   = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      sh_d  = {sh_q[INSTR_W-2*BYTE_W-1:0], byte_i};
      if (word_done_o) begin
        word_d = {sh_q, byte_i};
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      sh_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_valid_o = vld_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses count/data/checksum byte stream, writes IMEM,
// and keeps the CPU held until a verified image is in place.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned        IMEM_WORDS = 256,
  parameter logic [INSTR_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus,
  input  logic         reload,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_err
);

  ld_state_e state_q, state_d;

  logic [BYTE_W-1:0]  cnt_hi_q, cnt_hi_d;
  logic [BYTE_W-1:0]  csum_q, csum_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        wcnt_q, wcnt_d;
  logic [INSTR_W-1:0] addr_q, addr_d;
  logic               rdy_q, rdy_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               fire;
  logic               asm_clr;
  logic               asm_push;
  logic               word_done;
  logic               word_valid;
  logic [INSTR_W-1:0] word;
  logic [15:0]        n_hdr;

  assign fire     = bus.rx_valid && rdy_q;
  assign n_hdr    = {cnt_hi_q, bus.rx_byte};
  assign asm_push = fire && (state_q == S_DATA);

  byte_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_push),
    .byte_i       (bus.rx_byte),
    .word_done_o  (word_done),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    csum_d   = csum_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    asm_clr  = 1'b0;
    unique case (state_q)
      S_HDR0: begin
        if (fire) begin
          cnt_hi_d = bus.rx_byte;
          csum_d   = csum_q ^ bus.rx_byte;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (fire) begin
          cnt_d  = n_hdr;
          csum_d = csum_q ^ bus.rx_byte;
          if (32'(n_hdr) > IMEM_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_hdr == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          csum_d = csum_q ^ bus.rx_byte;
          if (word_done) begin
            addr_d = BASE_ADDR
                   + (32'(wcnt_q) << WADDR_SHIFT);
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q + 16'd1 == cnt_q)
              state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (fire) begin
          if (bus.rx_byte == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        // reload is only honoured once the load has finished either way
        if (reload) begin
          state_d  = S_HDR0;
          cnt_hi_d = '0;
          csum_d   = '0;
          cnt_d    = '0;
          wcnt_d   = '0;
          addr_d   = BASE_ADDR;
          hold_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
          asm_clr  = 1'b1;
        end
      end
      default: state_d = S_HDR0;
    endcase
    rdy_d = !((state_d == S_DONE) || (state_d == S_ERR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HDR0;
      cnt_hi_q <= '0;
      csum_q   <= '0;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      addr_q   <= BASE_ADDR;
      rdy_q    <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_hi_q <= cnt_hi_d;
      csum_q   <= csum_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      rdy_q    <= rdy_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.rx_ready   = rdy_q;
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign cpu_hold       = hold_q;
  assign load_done      = done_q;
  assign load_err       = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle `cpu`.
- Receives a byte stream from a host link (valid/ready) and assembles big-endian 32-bit instruction words.
- Writes those words into instruction memory through a one-word-per-cycle write port.
- Holds the CPU (PC and register-file/data-memory writes gated) until a complete, checksum-verified image is loaded.

Parameters:
- IMEM_WORDS, 256: capacity of instruction memory in words; larger images are rejected.
- BASE_ADDR, 32'h0000_0000: byte address of the first instruction written; must be word aligned.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  host byte is present on rx_byte.
- rx_byte  in  8  host byte.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
- reload  in  1  single-cycle pulse; restarts loading from DONE or ERR, ignored in other states.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address of the word being written.
- imem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  1 = CPU held in reset/stall.
- load_done  out  1  image loaded and verified.
- load_err  out  1  image rejected (oversize or checksum mismatch).

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state=HDR0, rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_hold=1, load_done=0, load_err=0.
  - Internal: word counter=0, byte index=0, running checksum=0.
- rx_ready is 1 in HDR0, HDR1, DATA and CSUM, and 0 in DONE and ERR. It is registered, so it is also 0 in the first cycle after reset release.
- Stream format: COUNT_HI, COUNT_LO (16-bit word count N, big-endian), then 4·N data bytes (MSB first per word), then one checksum byte.
- Checksum = XOR of every byte preceding it, including both header bytes.
- State machine:
  - HDR0: accept byte → store as count[15:8] → HDR1.
  - HDR1: accept byte → count[7:0].
    - If N > IMEM_WORDS → ERR.
    - Else if N == 0 → CSUM.
    - Else → DATA.
  - DATA: shift each accepted byte into the word (shift left 8); the byte index counts 0..3.
    - On the 4th byte: imem_we=1 for exactly the next cycle with the completed word, at imem_addr = BASE_ADDR + 4·k for the k-th word (0-based).
    - Advance k.
    - After word N-1 → CSUM.
  - CSUM: accept byte.
    - If it equals the running checksum → DONE (load_done=1, cpu_hold=0).
    - Else → ERR (load_err=1, cpu_hold stays 1).
  - DONE / ERR: sticky. A reload pulse clears flags, counters and checksum, sets cpu_hold=1, and returns to HDR0.
- Write timing:
  - imem_we/imem_addr/imem_wdata are registered, so the write appears the cycle after the 4th byte handshake.
  - Back-to-back words are legal at one byte per cycle. A new write therefore occurs at most every 4 cycles; no back-pressure is ever applied in DATA.
- Bubbles: rx_valid may drop at any point. State and partial words are held until the next valid byte.
- Address arithmetic: 32-bit, no wrap check is needed because the IMEM_WORDS bound guarantees the range.
- cpu_hold drops only in the same cycle load_done rises. cpu_hold is never 0 while load_err=1.
- Reset mid-load: all progress is discarded. Words already written stay in memory, but cpu_hold=1 prevents execution.
- reload asserted in non-terminal states: no effect.

Decomposition:
- Shared package `mips_pkg`:
  - loader state enum (HDR0, HDR1, DATA, CSUM, DONE, ERR).
  - INSTR_W=32, BYTE_W=8, word-address shift constant 2.
- One natural sub-module, `byte_word_assembler`: the shift register plus byte-index counter; outputs word_valid for one cycle with the assembled word.
- FSM, counters and checksum live in imem_loader.

Test Plan:
- Load image N=2, words 0x2008_0005 and 0x2009_0007 at one byte per cycle, correct checksum → two imem_we pulses:
  - addr 0x0 with 0x2008_0005;
  - addr 0x4 with 0x2009_0007.
  - Then load_done=1 and cpu_hold=0.
- Same image with a random rx_valid gap of 0–5 cycles between bytes → identical writes and data; rx_ready stays 1 throughout.
- N=0, checksum byte 0x00 → no imem_we pulse, load_done=1.
- Correct image but checksum byte flipped (XOR 0x01) → both words written, load_err=1, cpu_hold=1, rx_ready=0. Then pulse reload and resend a valid image → load_done=1.
- IMEM_WORDS=4, header N=5 → ERR immediately after COUNT_LO, no imem_we pulses, load_err=1.
- rst_n asserted after the 6th data byte of an N=2 load → all outputs return to reset values asynchronously. A full resend then completes with writes to 0x0 and 0x4.
